// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing recovery: measures line/frame geometry, locks, and regenerates x/y/video_on.
// Optional macro VGA_RX_SYNC_EN inserts a 2-flop synchronizer on hsync_in/vsync_in.
module vga_sync_receiver #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_BP        = 9,
  parameter int unsigned HD          = 640,
  parameter int unsigned VD          = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        sync_err
);

  localparam logic [10:0] CntMax = 11'h7ff;
  localparam logic [10:0] HTotal = 11'(H_TOTAL);
  localparam logic [10:0] VTotal = 11'(V_TOTAL);
  localparam logic [10:0] HBp    = 11'(H_BP);
  localparam logic [10:0] VBp    = 11'(V_BP);
  localparam logic [10:0] HEnd   = 11'(H_BP + HD);
  localparam logic [10:0] VEnd   = 11'(V_BP + VD);
  localparam logic [9:0]  HBpX   = 10'(H_BP);
  localparam logic [9:0]  VBpY   = 10'(V_BP);
  localparam logic [3:0]  LockN  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  logic hs_s, vs_s;

`ifdef VGA_RX_SYNC_EN
  logic [1:0] hs_meta_q, vs_meta_q;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      hs_meta_q <= '0;
      vs_meta_q <= '0;
    end else begin
      hs_meta_q <= {hs_meta_q[0], hsync_in};
      vs_meta_q <= {vs_meta_q[0], vsync_in};
    end
  end

  assign hs_s = hs_meta_q[1];
  assign vs_s = vs_meta_q[1];
`else
  assign hs_s = hsync_in;
  assign vs_s = vsync_in;
`endif

  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, hcnt_inc, vcnt_inc;
  logic        vs_pend_q, vs_pend_d;
  logic        line_seen_q, line_seen_d, frame_seen_q, frame_seen_d;
  logic        err_seen_q, err_seen_d;
  logic [3:0]  good_q, good_d;
  state_e      state_q, state_d;
  logic [10:0] line_len_d, frame_lines_d;
  logic [9:0]  x_d, y_d;
  logic        hs_fall, vs_fall, frame_end, mismatch, locked_d, de;

  assign hs_fall  = hs_prev_q & ~hs_s;
  assign vs_fall  = vs_prev_q & ~vs_s;
  assign hcnt_inc = (hcnt_q == CntMax) ? CntMax : hcnt_q + 11'd1;
  assign vcnt_inc = (vcnt_q == CntMax) ? CntMax : vcnt_q + 11'd1;

  // Measurement: the first line and first frame after reset are partial, so they are not judged.
  always_comb begin
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    vs_pend_d     = vs_pend_q;
    line_seen_d   = line_seen_q;
    frame_seen_d  = frame_seen_q;
    line_len_d    = line_len;
    frame_lines_d = frame_lines;
    frame_end     = 1'b0;
    mismatch      = 1'b0;
    if (p_tick) begin
      hs_prev_d = hs_s;
      vs_prev_d = vs_s;
      if (vs_fall) vs_pend_d = 1'b1;
      if (hs_fall) begin
        hcnt_d      = '0;
        line_seen_d = 1'b1;
        if (line_seen_q) begin
          line_len_d = hcnt_inc;
          if (hcnt_inc != HTotal) mismatch = 1'b1;
        end
        // A vs_fall on this very tick still closes the frame at this hs_fall.
        if (vs_pend_q || vs_fall) begin
          vcnt_d       = '0;
          vs_pend_d    = 1'b0;
          frame_end    = 1'b1;
          frame_seen_d = 1'b1;
          if (frame_seen_q) begin
            frame_lines_d = vcnt_inc;
            if (vcnt_inc != VTotal) mismatch = 1'b1;
          end
        end else begin
          vcnt_d = vcnt_inc;
        end
      end else begin
        hcnt_d = hcnt_inc;
        if (hcnt_q == CntMax - 11'd1) mismatch = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    err_seen_d = err_seen_q;
    if (p_tick) begin
      case (state_q)
        StSearch: begin
          if (frame_end) begin
            state_d    = StTrack;
            good_d     = '0;
            err_seen_d = 1'b0;
          end
        end
        StTrack: begin
          if (frame_end) begin
            err_seen_d = 1'b0;
            if (mismatch || err_seen_q) begin
              good_d = '0;
            end else begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LockN) state_d = StLocked;
            end
          end else if (mismatch) begin
            good_d     = '0;
            err_seen_d = 1'b1;
          end
        end
        StLocked: begin
          if (mismatch) begin
            state_d    = StTrack;
            good_d     = '0;
            err_seen_d = ~frame_end;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  assign locked_d = (state_d == StLocked);
  assign de = locked_d && (hcnt_d >= HBp) && (hcnt_d < HEnd) && (vcnt_d >= VBp) && (vcnt_d < VEnd);
  assign x_d = de ? hcnt_d[9:0] - HBpX : '0;
  assign y_d = de ? vcnt_d[9:0] - VBpY : '0;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      vs_pend_q    <= 1'b0;
      line_seen_q  <= 1'b0;
      frame_seen_q <= 1'b0;
      err_seen_q   <= 1'b0;
      good_q       <= '0;
      state_q      <= StSearch;
      x            <= '0;
      y            <= '0;
      video_on     <= 1'b0;
      locked       <= 1'b0;
      line_len     <= '0;
      frame_lines  <= '0;
      sync_err     <= 1'b0;
    end else begin
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      vs_pend_q    <= vs_pend_d;
      line_seen_q  <= line_seen_d;
      frame_seen_q <= frame_seen_d;
      err_seen_q   <= err_seen_d;
      good_q       <= good_d;
      state_q      <= state_d;
      x            <= x_d;
      y            <= y_d;
      video_on     <= de;
      locked       <= locked_d;
      line_len     <= line_len_d;
      frame_lines  <= frame_lines_d;
      sync_err     <= mismatch;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a scaled-down timing generator model
// (20 ticks/line, 12 lines/frame) so several full frames fit in a short run.
module tb_vga_sync_receiver;

  localparam int HTot    = 20;
  localparam int VTot    = 12;
  localparam int HBp     = 4;
  localparam int VBp     = 2;
  localparam int Hd      = 10;
  localparam int Vd      = 6;
  localparam int HsStart = 12;
  localparam int HsEnd   = 16;
  localparam int VsLine  = 7;
  localparam int FeLine  = 9;

  logic        clk_100MHz = 1'b0;
  logic        reset_n    = 1'b0;
  logic        p_tick     = 1'b0;
  logic        hsync_in   = 1'b0;
  logic        vsync_in   = 1'b0;
  logic [9:0]  x, y;
  logic        video_on, locked, sync_err;
  logic [10:0] line_len, frame_lines;

  int checks = 0;
  int errors = 0;
  int gh = 0, gv = 0, sgh = 0, sgv = 0, frame_no = 0;
  int vs_off = 0;
  bit hs_mask = 1'b0;

  always #5 clk_100MHz = ~clk_100MHz;

  vga_sync_receiver #(
    .H_TOTAL(HTot), .V_TOTAL(VTot), .H_BP(HBp), .V_BP(VBp),
    .HD(Hd), .VD(Vd), .LOCK_FRAMES(2)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .p_tick     (p_tick),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .locked     (locked),
    .line_len   (line_len),
    .frame_lines(frame_lines),
    .sync_err   (sync_err)
  );

  // One generator pixel: sync levels for (gh,gv) sampled on one p_tick, outputs valid on return.
  task automatic gen_tick();
    int pos;
    @(posedge clk_100MHz); #1;
    pos      = gv * HTot + gh;
    hsync_in = !hs_mask && gh >= HsStart && gh < HsEnd;
    vsync_in = pos >= VsLine * HTot + vs_off && pos < (VsLine + 2) * HTot + vs_off;
    p_tick   = 1'b1;
    @(posedge clk_100MHz); #1;
    p_tick = 1'b0;
    sgh    = gh;
    sgv    = gv;
    gh++;
    if (gh == HTot) begin
      gh = 0;
      gv++;
      if (gv == VTot) begin
        gv = 0;
        frame_no++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #1;
    checks++;
    if (x !== 10'd0 || y !== 10'd0 || video_on !== 1'b0) begin
      errors++;
      $display("FAIL reset_xy: x=%0d y=%0d video_on=%b, want 0 0 0", x, y, video_on);
    end
    checks++;
    if (locked !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: locked=%b sync_err=%b, want 0 0", locked, sync_err);
    end
    checks++;
    if (line_len !== 11'd0 || frame_lines !== 11'd0) begin
      errors++;
      $display("FAIL reset_geom: line_len=%0d frame_lines=%0d, want 0 0", line_len, frame_lines);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_lock_acquire();
    int fe = 0;
    bit exp_lk = 1'b0;
    bit e_on;
    logic [9:0] ex, ey;
    for (int t = 0; t < 4 * HTot * VTot; t++) begin
      gen_tick();
      if (sgv == FeLine && sgh == HsEnd) begin
        fe++;
        if (fe == 3) exp_lk = 1'b1;
      end
      e_on = exp_lk && sgh < Hd && sgv < Vd;
      ex   = e_on ? 10'(sgh) : 10'd0;
      ey   = e_on ? 10'(sgv) : 10'd0;
      checks++;
      if (locked !== exp_lk) begin
        errors++;
        $display("FAIL acq_locked at (%0d,%0d): got %b want %b", sgh, sgv, locked, exp_lk);
      end
      checks++;
      if (video_on !== e_on || x !== ex || y !== ey) begin
        errors++;
        $display("FAIL acq_pixel at (%0d,%0d): got on=%b x=%0d y=%0d want on=%b x=%0d y=%0d",
                 sgh, sgv, video_on, x, y, e_on, ex, ey);
      end
      checks++;
      if (sync_err !== 1'b0) begin
        errors++;
        $display("FAIL acq_sync_err at (%0d,%0d): got 1 want 0", sgh, sgv);
      end
    end
    checks++;
    if (line_len !== 11'd20 || frame_lines !== 11'd12) begin
      errors++;
      $display("FAIL acq_geom: line_len=%0d frame_lines=%0d want 20 12", line_len, frame_lines);
    end
  endtask

  task automatic test_active_frame();
    int n_on = 0;
    int fx = -1, fy = -1, lx = -1, ly = -1;
    for (int t = 0; t < HTot * VTot; t++) begin
      gen_tick();
      if (video_on === 1'b1) begin
        if (n_on == 0) begin
          fx = int'(x);
          fy = int'(y);
        end
        lx = int'(x);
        ly = int'(y);
        n_on++;
      end
    end
    checks++;
    if (n_on != Hd * Vd) begin
      errors++;
      $display("FAIL active_count: got %0d want %0d", n_on, Hd * Vd);
    end
    checks++;
    if (fx != 0 || fy != 0) begin
      errors++;
      $display("FAIL active_first: got (%0d,%0d) want (0,0)", fx, fy);
    end
    checks++;
    if (lx != Hd - 1 || ly != Vd - 1) begin
      errors++;
      $display("FAIL active_last: got (%0d,%0d) want (%0d,%0d)", lx, ly, Hd - 1, Vd - 1);
    end
  endtask

  task automatic test_short_line();
    int f0 = frame_no;
    int fe_after = 0;
    bit exp_lk = 1'b1;
    bit hit = 1'b0;
    bit err_tick;
    while (frame_no < f0 + 3) begin
      gen_tick();
      if (frame_no == f0 && sgv == 3 && sgh == 17) gh++;  // drop one blanking pixel
      err_tick = (frame_no == f0 && sgv == 4 && sgh == HsEnd);
      if (err_tick) begin
        exp_lk = 1'b0;
        hit    = 1'b1;
        checks++;
        if (line_len !== 11'd19) begin
          errors++;
          $display("FAIL short_line_len: got %0d want 19", line_len);
        end
      end
      if (hit && sgv == FeLine && sgh == HsEnd) begin
        fe_after++;
        if (fe_after == 3) exp_lk = 1'b1;
      end
      checks++;
      if (sync_err !== err_tick) begin
        errors++;
        $display("FAIL short_sync_err at (%0d,%0d): got %b want %b", sgh, sgv, sync_err, err_tick);
      end
      checks++;
      if (locked !== exp_lk) begin
        errors++;
        $display("FAIL short_locked at (%0d,%0d): got %b want %b", sgh, sgv, locked, exp_lk);
      end
    end
    checks++;
    if (line_len !== 11'd20) begin
      errors++;
      $display("FAIL short_recover_len: got %0d want 20", line_len);
    end
  endtask

  task automatic test_coincident();
    int f0 = frame_no;
    vs_off = HsEnd;
    while (frame_no < f0 + 2) begin
      gen_tick();
      checks++;
      if (sync_err !== 1'b0 || locked !== 1'b1) begin
        errors++;
        $display("FAIL coinc_status at (%0d,%0d): sync_err=%b locked=%b want 0 1",
                 sgh, sgv, sync_err, locked);
      end
      if (sgv == FeLine && sgh == HsEnd) begin
        checks++;
        if (frame_lines !== 11'd12) begin
          errors++;
          $display("FAIL coinc_frame_lines: got %0d want 12", frame_lines);
        end
      end
      if (sgv == 0 && sgh == 0) begin
        checks++;
        if (video_on !== 1'b1 || x !== 10'd0 || y !== 10'd0) begin
          errors++;
          $display("FAIL coinc_origin: on=%b x=%0d y=%0d want 1 0 0", video_on, x, y);
        end
      end
    end
    vs_off = 0;
  endtask

  task automatic test_reset_mid_line();
    int fe = 0;
    bit exp_lk = 1'b0;
    for (int t = 0; t < HTot * VTot && !(sgv == 3 && sgh == 5); t++) gen_tick();
    checks++;
    if (video_on !== 1'b1 || x !== 10'd5 || y !== 10'd3) begin
      errors++;
      $display("FAIL midrst_before: on=%b x=%0d y=%0d want 1 5 3", video_on, x, y);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({x, y, video_on, locked, line_len, frame_lines, sync_err} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: x=%0d y=%0d on=%b lk=%b ll=%0d fl=%0d err=%b want all 0",
               x, y, video_on, locked, line_len, frame_lines, sync_err);
    end
    @(posedge clk_100MHz); #1;
    reset_n = 1'b1;
    for (int t = 0; t < 4 * HTot * VTot && fe < 3; t++) begin
      gen_tick();
      if (sgv == FeLine && sgh == HsEnd) begin
        fe++;
        if (fe == 3) exp_lk = 1'b1;
      end
      checks++;
      if (locked !== exp_lk) begin
        errors++;
        $display("FAIL midrst_relock at (%0d,%0d) fe=%0d: got %b want %b",
                 sgh, sgv, fe, locked, exp_lk);
      end
    end
    while (!(gh == 0 && gv == 0)) gen_tick();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL midrst_final_lock: got %b want 1", locked);
    end
  endtask

  task automatic test_lost_hsync();
    int pulses = 0;
    int pulse_t = -1;
    hs_mask = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      gen_tick();
      if (sync_err === 1'b1) begin
        pulses++;
        pulse_t = t;
      end
      if (t == 2042 || t == 2043) begin
        checks++;
        if (locked !== (t == 2042)) begin
          errors++;
          $display("FAIL lost_lock_edge t=%0d: got %b want %b", t, locked, t == 2042);
        end
      end
    end
    checks++;
    if (pulses != 1 || pulse_t != 2043) begin
      errors++;
      $display("FAIL lost_pulses: got %0d pulses last at t=%0d want 1 at t=2043", pulses, pulse_t);
    end
    checks++;
    if (locked !== 1'b0 || video_on !== 1'b0) begin
      errors++;
      $display("FAIL lost_state: locked=%b video_on=%b want 0 0", locked, video_on);
    end
    hs_mask = 1'b0;
    for (int t = 0; t < HTot; t++) begin
      gen_tick();
      if (sgh == HsEnd) begin
        checks++;
        if (line_len !== 11'd2047 || sync_err !== 1'b1) begin
          errors++;
          $display("FAIL lost_resume: line_len=%0d sync_err=%b want 2047 1", line_len, sync_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_active_frame();
    test_short_line();
    test_coincident();
    test_reset_mid_line();
    test_lost_hsync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
